// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control sequencer: control-bundle bit
// positions, stage field widths and the sequencer state encoding.
package pipe_ctrl_pkg;

  // bit positions inside the 9-bit ID control bundle
  localparam int WB_MEMTOREG = 8;
  localparam int WB_REGWRITE = 7;
  localparam int M_BRANCH    = 6;
  localparam int M_MEMREAD   = 5;
  localparam int M_MEMWRITE  = 4;
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 2;
  localparam int EX_RTYPE    = 1;
  localparam int EX_BEQ      = 0;

  // field widths; the EX/MEM register keeps only the M and WB fields
  localparam int WB_W   = 2;
  localparam int M_W    = 3;
  localparam int EX_W   = 4;
  localparam int MEMB_W = WB_W + M_W;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_det.sv
// Combinational stall detection for the instruction sitting in ID.
// Build option PIPE_CTRL_FWD_EN: when defined, a forwarding unit is assumed
// and only load-use dependencies stall; otherwise every RAW dependency on
// the EX or MEM stage stalls. Register 0 never creates a dependency.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              stall
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = (ex_dst != '0) &&
                   ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_hit = (mem_dst != '0) &&
                   ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));

`ifdef PIPE_CTRL_FWD_EN
  // regwrite bits and the MEM-stage compare are not needed when forwarding
  logic unused_fwd;
  assign unused_fwd = ^{ex_regwrite, mem_regwrite, mem_hit};
  assign stall      = ex_memread && ex_hit;
`else
  // a load always writes a register, so the memread term is kept only for
  // robustness against odd decoder bundles
  assign stall = ((ex_memread || ex_regwrite) && ex_hit) ||
                 (mem_regwrite && mem_hit);
`endif

endmodule

// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer for the 5-stage MIPS core. Carries the decoded
// control bundle through ID/EX, EX/MEM and MEM/WB, inserts bubbles on
// hazards, flushes on taken branches / jumps and freezes during data
// memory handshakes. Build option: PIPE_CTRL_FWD_EN (see pipe_hazard_det).
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   ST_RUN      | pipe advancing normally
//   ST_MEM_WAIT | data memory request outstanding, pipe frozen until ack
module pipe_ctrl_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W = 9,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              mem_branch_taken,
  input  logic              dmem_ack,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              pc_sel_branch,
  output logic [EX_W-1:0]   ex_ctrl,
  output logic [M_W-1:0]    mem_ctrl,
  output logic [WB_W-1:0]   wb_ctrl,
  output logic [REG_AW-1:0] ex_dst,
  output logic [REG_AW-1:0] mem_dst,
  output logic [REG_AW-1:0] wb_dst,
  output logic              dmem_req,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state, state_nxt;
  logic [CTRL_W-1:0]   ex_bundle;
  logic [MEMB_W-1:0]   mem_bundle;
  logic                frozen;
  logic                hz_stall;
  logic                bubble_ex;
  logic                bubble_mem;
  logic [1:0]          bub_add;
  logic [CNT_W-1:0]    bub_add_ext;

  assign ex_ctrl     = ex_bundle[EX_REGDST:EX_BEQ];
  assign mem_ctrl    = mem_bundle[M_W-1:0];
  assign dmem_req    = mem_ctrl[M_MEMREAD-M_MEMWRITE] | mem_ctrl[0];
  assign frozen      = ~dmem_ack & ((state == ST_MEM_WAIT) | dmem_req);
  assign bub_add_ext = CNT_W'(bub_add);

  pipe_hazard_det #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_memread   (ex_bundle[M_MEMREAD]),
    .ex_regwrite  (ex_bundle[WB_REGWRITE]),
    .ex_dst       (ex_dst),
    .mem_regwrite (mem_bundle[WB_REGWRITE-M_MEMWRITE]),
    .mem_dst      (mem_dst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .stall        (hz_stall)
  );

  // sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // next state and per-cycle pipe control: freeze > flush > stall > jump
  always_comb begin
    state_nxt     = state;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    pc_sel_branch = 1'b0;
    bubble_ex     = 1'b0;
    bubble_mem    = 1'b0;
    bub_add       = 2'd0;

    case (state)
      ST_RUN:      if (dmem_req && !dmem_ack) state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ack)              state_nxt = ST_RUN;
      default:                                state_nxt = ST_RUN;
    endcase

    if (frozen) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (mem_branch_taken) begin
      pc_sel_branch = 1'b1;
      ifid_flush    = 1'b1;
      bubble_ex     = 1'b1;
      bubble_mem    = 1'b1;
      bub_add       = 2'd2;
    end else if (hz_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble_ex  = 1'b1;
      bub_add    = 2'd1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // stage control registers; bubbles clear both control and destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_bundle  <= '0;
      ex_dst     <= '0;
      mem_bundle <= '0;
      mem_dst    <= '0;
      wb_ctrl    <= '0;
      wb_dst     <= '0;
    end else if (!frozen) begin
      wb_ctrl <= mem_bundle[MEMB_W-1:M_W];
      wb_dst  <= mem_dst;
      if (bubble_mem) begin
        mem_bundle <= '0;
        mem_dst    <= '0;
      end else begin
        mem_bundle <= ex_bundle[WB_MEMTOREG:M_MEMWRITE];
        mem_dst    <= ex_dst;
      end
      if (bubble_ex) begin
        ex_bundle <= '0;
        ex_dst    <= '0;
      end else begin
        ex_bundle <= id_ctrl;
        ex_dst    <= id_dst;
      end
    end
  end

  // saturating bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (bub_add != 2'd0) begin
      if (bubble_cnt > (CNT_MAX - bub_add_ext)) bubble_cnt <= CNT_MAX;
      else                                      bubble_cnt <= bubble_cnt + bub_add_ext;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Self-checking bench for pipe_ctrl_seq: directed scenarios plus a random
// run against a stage-level reference model.
module tb_pipe_ctrl_seq;

  localparam logic [8:0] C_NOP = 9'h000;
  localparam logic [8:0] C_LW  = 9'h1A4;
  localparam logic [8:0] C_ADD = 9'h08A;
  localparam logic [8:0] C_SW  = 9'h014;
  localparam logic [8:0] C_BEQ = 9'h041;

`ifdef PIPE_CTRL_FWD_EN
  localparam int LW_BUB  = 1;
  localparam int RAW_BUB = 0;
`else
  localparam int LW_BUB  = 2;
  localparam int RAW_BUB = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  id_ctrl = '0;
  logic        id_jump = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
  logic        id_uses_rt = 1'b0;
  logic        mem_branch_taken = 1'b0;
  logic        dmem_ack = 1'b1;
  logic        pc_write, ifid_write, ifid_flush, pc_sel_branch, dmem_req;
  logic [3:0]  ex_ctrl;
  logic [2:0]  mem_ctrl;
  logic [1:0]  wb_ctrl;
  logic [4:0]  ex_dst, mem_dst, wb_dst;
  logic [15:0] bubble_cnt;
  logic [44:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  // model: full bundle of the instruction occupying each stage
  logic [8:0] m_ex, m_mem, m_wb;
  logic [4:0] m_exd, m_memd, m_wbd;
  int         m_cnt;

  pipe_ctrl_seq dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_jump(id_jump),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .mem_branch_taken(mem_branch_taken), .dmem_ack(dmem_ack),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .pc_sel_branch(pc_sel_branch), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .dmem_req(dmem_req), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, ifid_write, ifid_flush, pc_sel_branch, ex_ctrl,
                mem_ctrl, wb_ctrl, ex_dst, mem_dst, wb_dst, dmem_req, bubble_cnt};

  task automatic drive(input logic [8:0] c, input logic j, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] d);
    id_ctrl = c; id_jump = j; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_dst = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(C_NOP, 0, 0, 0, 0, 0);
    mem_branch_taken = 1'b0;
    dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_ex = '0; m_mem = '0; m_wb = '0; m_exd = '0; m_memd = '0; m_wbd = '0; m_cnt = 0;
  endtask

  function automatic bit reads(input logic [4:0] r, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt);
    return (r != 0) && ((r == rs) || (urt && (r == rt)));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (obs !== {2'b11, 43'b0}) begin
      n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, {2'b11, 43'b0});
    end
    apply_reset();
  endtask

  // counts stall cycles while the dependent instruction is held in ID
  task automatic test_load_use();
    int stalls = 0;
    apply_reset();
    drive(C_LW, 0, 1, 0, 0, 2);
    @(negedge clk);
    drive(C_ADD, 0, 2, 4, 1, 3);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (pc_write !== 1'b1) begin
        stalls++;
        if (k == 0) begin
          n_checks++;
          if (ifid_write !== 1'b0) begin
            n_fail++; $display("FAIL lu_ifid_write got=%b exp=0", ifid_write);
          end
        end
        @(negedge clk);
        if (k == 0) begin
          n_checks++;
          if (ex_ctrl !== 4'h0) begin
            n_fail++; $display("FAIL lu_ex_bubble got=%h exp=0", ex_ctrl);
          end
        end
      end else break;
    end
    @(negedge clk);
    drive(C_NOP, 0, 0, 0, 0, 0);
    n_checks++;
    if (stalls != LW_BUB) begin
      n_fail++; $display("FAIL lu_stall_cycles got=%0d exp=%0d", stalls, LW_BUB);
    end
    n_checks++;
    if (bubble_cnt !== 16'(LW_BUB)) begin
      n_fail++; $display("FAIL lu_bubble_cnt got=%0d exp=%0d", bubble_cnt, LW_BUB);
    end
  endtask

  task automatic test_reg0();
    apply_reset();
    drive(C_LW, 0, 1, 0, 0, 0);
    @(negedge clk);
    drive(C_ADD, 0, 0, 0, 1, 3);
    #1;
    n_checks++;
    if (pc_write !== 1'b1) begin
      n_fail++; $display("FAIL r0_pc_write got=%b exp=1", pc_write);
    end
    @(negedge clk);
    drive(C_NOP, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (pc_write !== 1'b1 || bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL r0_no_bubble got=%b/%0d exp=1/0", pc_write, bubble_cnt);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    drive(C_BEQ, 0, 1, 2, 1, 0);
    @(negedge clk);
    drive(C_SW, 0, 1, 2, 1, 0);
    @(negedge clk);
    drive(C_ADD, 0, 6, 7, 1, 8);
    mem_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({pc_sel_branch, ifid_flush, pc_write} !== 3'b111) begin
      n_fail++; $display("FAIL br_flush_ctl got=%b exp=111", {pc_sel_branch, ifid_flush, pc_write});
    end
    @(negedge clk);
    mem_branch_taken = 1'b0;
    drive(C_NOP, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if ({ex_ctrl, mem_ctrl, pc_sel_branch, ifid_flush} !== 9'b0) begin
      n_fail++; $display("FAIL br_younger_cleared got=%h/%h/%b/%b exp=0", ex_ctrl, mem_ctrl, pc_sel_branch, ifid_flush);
    end
    n_checks++;
    if (bubble_cnt !== 16'd2) begin
      n_fail++; $display("FAIL br_bubble_cnt got=%0d exp=2", bubble_cnt);
    end
  endtask

  task automatic test_mem_wait();
    int frz = 0;
    apply_reset();
    drive(C_SW, 0, 1, 2, 1, 0);
    @(negedge clk);
    drive(C_ADD, 0, 1, 1, 1, 9);
    @(negedge clk);
    drive(C_LW, 0, 3, 0, 0, 10);
    dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_branch_taken = (k == 1);
      #1;
      if (pc_write === 1'b0 && ifid_write === 1'b0 && dmem_req === 1'b1 &&
          mem_ctrl === 3'b001 && ex_ctrl === 4'hA && pc_sel_branch === 1'b0 &&
          mem_dst === 5'd0 && ex_dst === 5'd9) frz++;
      @(negedge clk);
    end
    mem_branch_taken = 1'b0;
    n_checks++;
    if (frz != 3) begin
      n_fail++; $display("FAIL mw_frozen_cycles got=%0d exp=3", frz);
    end
    dmem_ack = 1'b1;
    #1;
    n_checks++;
    if (pc_write !== 1'b1) begin
      n_fail++; $display("FAIL mw_release got=%b exp=1", pc_write);
    end
    @(negedge clk);
    drive(C_NOP, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if ({mem_ctrl, mem_dst, ex_ctrl, bubble_cnt} !== {3'b000, 5'd9, 4'h4, 16'd0}) begin
      n_fail++; $display("FAIL mw_advance got=%h/%0d/%h/%0d exp=0/9/4/0", mem_ctrl, mem_dst, ex_ctrl, bubble_cnt);
    end
  endtask

  task automatic test_branch_vs_hazard();
    apply_reset();
    drive(C_LW, 0, 1, 0, 0, 2);
    @(negedge clk);
    drive(C_ADD, 0, 2, 4, 1, 3);
    mem_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({pc_write, ifid_write, pc_sel_branch, ifid_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL bh_flush_wins got=%b exp=1111", {pc_write, ifid_write, pc_sel_branch, ifid_flush});
    end
    @(negedge clk);
    mem_branch_taken = 1'b0;
    drive(C_NOP, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (bubble_cnt !== 16'd2 || ex_ctrl !== 4'h0) begin
      n_fail++; $display("FAIL bh_bubbles got=%0d/%h exp=2/0", bubble_cnt, ex_ctrl);
    end
  endtask

  task automatic test_raw();
    int stalls = 0;
    apply_reset();
    drive(C_ADD, 0, 1, 1, 1, 2);
    @(negedge clk);
    drive(C_ADD, 0, 2, 2, 1, 5);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (pc_write !== 1'b1) begin stalls++; @(negedge clk); end
      else break;
    end
    @(negedge clk);
    drive(C_NOP, 0, 0, 0, 0, 0);
    n_checks++;
    if (stalls != RAW_BUB || bubble_cnt !== 16'(RAW_BUB)) begin
      n_fail++; $display("FAIL raw_bubbles got=%0d/%0d exp=%0d", stalls, bubble_cnt, RAW_BUB);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    mem_branch_taken = 1'b1;
    @(negedge clk);
    mem_branch_taken = 1'b0;
    drive(C_SW, 0, 1, 2, 1, 0);
    @(negedge clk);
    drive(C_NOP, 0, 0, 0, 0, 0);
    dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    n_checks++;
    if (pc_write !== 1'b0 || dmem_req !== 1'b1 || bubble_cnt !== 16'd2) begin
      n_fail++; $display("FAIL ar_waiting got=%b/%b/%0d exp=0/1/2", pc_write, dmem_req, bubble_cnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== {2'b11, 43'b0}) begin
      n_fail++; $display("FAIL ar_async_clear got=%h exp=%h", obs, {2'b11, 43'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b0;
    #1;
    n_checks++;
    if (pc_write !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++; $display("FAIL ar_back_to_run got=%b/%b exp=1/0", pc_write, dmem_req);
    end
    dmem_ack = 1'b1;
  endtask

  task automatic test_random();
    logic [44:0] exp;
    bit req, frozen, haz, flush, stall, jmp;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive(9'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)));
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      dmem_ack = 1'($urandom);
      #1;
      req    = m_mem[5] || m_mem[4];
      frozen = req && !dmem_ack;
      haz    = m_ex[5] && reads(m_exd, id_rs, id_rt, id_uses_rt);
`ifndef PIPE_CTRL_FWD_EN
      haz = haz || (m_ex[7] && reads(m_exd, id_rs, id_rt, id_uses_rt)) ||
                   (m_mem[7] && reads(m_memd, id_rs, id_rt, id_uses_rt));
`endif
      flush = !frozen && mem_branch_taken;
      stall = !frozen && !flush && haz;
      jmp   = !frozen && !flush && !stall && id_jump;
      exp = {!(frozen || stall), !(frozen || stall), flush || jmp, flush,
             m_ex[3:0], m_mem[6:4], m_wb[8:7], m_exd, m_memd, m_wbd, req, 16'(m_cnt)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL rand_cycle_%0d got=%h exp=%h", cyc, obs, exp);
      end
      if (!frozen) begin
        m_wb = m_mem; m_wbd = m_memd;
        if (flush) begin m_mem = '0; m_memd = '0; end
        else begin m_mem = m_ex; m_memd = m_exd; end
        if (flush || stall) begin m_ex = '0; m_exd = '0; end
        else begin m_ex = id_ctrl; m_exd = id_dst; end
        m_cnt = m_cnt + (flush ? 2 : (stall ? 1 : 0));
        if (m_cnt > 65535) m_cnt = 65535;
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    mem_branch_taken = 1'b1;
    repeat (32767) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (bubble_cnt !== 16'd65534) begin
      n_fail++; $display("FAIL sat_near_max got=%0d exp=65534", bubble_cnt);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_plus2 got=%0d exp=65535", bubble_cnt);
    end
    mem_branch_taken = 1'b0;
    drive(C_LW, 0, 1, 0, 0, 2);
    @(negedge clk);
    drive(C_ADD, 0, 2, 4, 1, 3);
    #1;
    n_checks++;
    if (pc_write !== 1'b0) begin
      n_fail++; $display("FAIL sat_stall got=%b exp=0", pc_write);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_plus1 got=%0d exp=65535", bubble_cnt);
    end
  endtask

  task automatic test_jump();
    apply_reset();
    drive(C_NOP, 1, 0, 0, 0, 0);
    #1;
    n_checks++;
    if ({ifid_flush, pc_sel_branch, pc_write} !== 3'b101) begin
      n_fail++; $display("FAIL jump_flush got=%b exp=101", {ifid_flush, pc_sel_branch, pc_write});
    end
    @(negedge clk);
    drive(C_NOP, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (ifid_flush !== 1'b0 || bubble_cnt !== 16'd0) begin
      n_fail++; $display("FAIL jump_one_cycle got=%b/%0d exp=0/0", ifid_flush, bubble_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg0();
    test_branch();
    test_mem_wait();
    test_branch_vs_hazard();
    test_raw();
    test_jump();
    test_async_reset();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
